// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and default operand width.
package serial_add_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell, LSB first, one bit
// per clock with a registered carry; result returned with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sa_state_t        r_state;
    sa_state_t        w_state_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;

    fa_cell u_fa (
        .a    (r_op_a[0]),
        .b    (r_op_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_sum   <= '0;
                        r_carry <= carry_in;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
                    r_sum   <= (r_sum >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry;

endmodule
